// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
package uart_pkg;
    localparam int N_REQ_MAX = 8;
    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    typedef enum logic [1:0] {IDLE, HEADER, STREAM} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);
    logic [IW-1:0] k;

    // Walk from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        k         = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            k = IW'((int'(last_grant) + i) % N_REQ);
            if (req[k]) begin
                grant     = '0;
                grant[k]  = 1'b1;
                grant_idx = k;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter feeding the UART TX FIFO from N_REQ byte streams.
// Define UART_TX_ARB_ID_HEADER_EN to prefix every packet with {4'hA, owner id}.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic               fifo_full_i,
    output logic               fifo_wr_en_o,
    output logic [7:0]         fifo_data_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               timeout_o
);
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    logic [N_REQ-1:0] grant_q, arb_grant;
    logic [IW-1:0]    gidx, last_grant, arb_idx;
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_q;
    logic             vld_g, last_g, xfer, hdr_wr;
    logic [7:0]       data_g;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req        (req_valid_i),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    assign vld_g  = req_valid_i[gidx];
    assign last_g = req_last_i[gidx];
    assign data_g = req_data_i[{gidx, 3'b000} +: 8];

    assign req_ready_o = (state == STREAM && !fifo_full_i) ? grant_q : '0;
    assign xfer        = (state == STREAM) && vld_g && !fifo_full_i;
`ifdef UART_TX_ARB_ID_HEADER_EN
    assign hdr_wr      = (state == HEADER) && !fifo_full_i;
    assign fifo_data_o = hdr_wr ? {HDR_NIBBLE, 4'(gidx)} : data_g;
`else
    assign hdr_wr      = 1'b0;
    assign fifo_data_o = data_g;
`endif
    assign fifo_wr_en_o = xfer | hdr_wr;

    assign grant_o   = grant_q;
    assign busy_o    = (state != IDLE);
    assign timeout_o = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            gidx       <= '0;
            last_grant <= IW'(N_REQ - 1);
            idle_cnt   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (|req_valid_i) begin
                        grant_q <= arb_grant;
                        gidx    <= arb_idx;
`ifdef UART_TX_ARB_ID_HEADER_EN
                        state   <= HEADER;
`else
                        state   <= STREAM;
`endif
                    end
                end
                HEADER: begin
                    if (!fifo_full_i) state <= STREAM;
                end
                STREAM: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (last_g) begin
                            state      <= IDLE;
                            grant_q    <= '0;
                            last_grant <= gidx;
                        end
                    end else if (!fifo_full_i && !vld_g) begin
                        // Owner went quiet: revoke so others are not starved.
                        if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                            timeout_q  <= 1'b1;
                            state      <= IDLE;
                            grant_q    <= '0;
                            last_grant <= gidx;
                            idle_cnt   <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench; expected FIFO stream comes from a packet-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;
`ifdef UART_TX_ARB_ID_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid_i, req_last_i, req_ready_o;
    logic [8*N-1:0] req_data_i;
    logic           fifo_full_i, fifo_wr_en_o;
    logic [7:0]     fifo_data_o;
    logic [N-1:0]   grant_o;
    logic           busy_o, timeout_o;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i),
        .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // requester-side packet storage
    logic [7:0] bmem [N][64];
    bit         lmem [N][64];
    int         blen [N];
    int         bptr [N];
    int         gap  [N];

    logic [7:0] exp_q[$];
    int         own_q[$];
    int         mdl_last;
    int         gapmax;
    bit         rnd_full, rnd_mode, full_drv;
    int         n_chk, n_pass, n_fail, n_wr;

    logic         s_wr, s_busy, s_to;
    logic [7:0]   s_data;
    logic [N-1:0] s_grant, s_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int k, input logic [7:0] b);
        exp_q.push_back(b);
        own_q.push_back(k);
    endtask

    task automatic push_hdr(input int k);
        if (HDR != 0) push_exp(k, 8'hA0 | 8'(k));
    endtask

    task automatic load_pkt(input int k, input int len, input logic [7:0] first, input logic [7:0] inc);
        if (bptr[k] == blen[k]) begin
            bptr[k] = 0;
            blen[k] = 0;
        end
        for (int i = 0; i < len; i++) begin
            bmem[k][blen[k]] = (inc == 8'h00) ? 8'($urandom) : 8'(first + 8'(i) * inc);
            lmem[k][blen[k]] = (i == len - 1);
            blen[k]++;
        end
    endtask

    // Whole packets, round-robin among requesters with pending packets.
    task automatic build_expected();
        int p[N];
        int nk;
        for (int k = 0; k < N; k++) p[k] = bptr[k];
        forever begin
            nk = -1;
            for (int i = 1; i <= N; i++) begin
                int k = (mdl_last + i) % N;
                if (nk < 0 && p[k] < blen[k]) nk = k;
            end
            if (nk < 0) break;
            push_hdr(nk);
            forever begin
                push_exp(nk, bmem[nk][p[nk]]);
                p[nk]++;
                if (lmem[nk][p[nk]-1]) break;
            end
            mdl_last = nk;
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        if (rnd_full) full_drv = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < N; k++) begin
            logic v;
            v = (bptr[k] < blen[k]) && (gap[k] == 0);
            req_valid_i[k]       = v;
            req_last_i[k]        = v && lmem[k][bptr[k]];
            req_data_i[8*k +: 8] = v ? bmem[k][bptr[k]] : 8'h00;
        end
        fifo_full_i = full_drv;
        #1;
        s_wr = fifo_wr_en_o; s_data = fifo_data_o; s_grant = grant_o;
        s_busy = busy_o; s_to = timeout_o; s_ready = req_ready_o;
        if (s_wr) begin
            n_wr++;
            if (exp_q.size() == 0) chk("unexpected_wr", 32'(s_wr), 0);
            else begin
                chk("wr_data", 32'(s_data), 32'(exp_q[0]));
                chk("wr_owner", 32'(s_grant), 32'(1) << own_q[0]);
                void'(exp_q.pop_front());
                void'(own_q.pop_front());
            end
        end
        chk("wr_while_full", 32'(s_wr & fifo_full_i), 0);
        chk("ready_mask", 32'(s_ready & ~s_grant), 0);
        chk("busy_vs_grant", 32'(s_busy), 32'(|s_grant));
        if (rnd_mode) chk("no_timeout", 32'(s_to), 0);
        acc = req_valid_i & req_ready_o;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                if (!lmem[k][bptr[k]] && gapmax > 0) gap[k] = $urandom_range(0, gapmax);
                bptr[k]++;
            end else if (gap[k] > 0) gap[k]--;
        end
    endtask

    task automatic drain(input string tag, input int bound);
        int c = 0;
        while ((exp_q.size() > 0 || s_busy) && c < bound) begin
            step();
            c++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        step();
        chk({tag, "_idle_grant"}, 32'(s_grant), 0);
        chk({tag, "_idle_busy"}, 32'(s_busy), 0);
    endtask

    task automatic run_until_wr(input int target, input int bound);
        int c = 0;
        while (n_wr < target && c < bound) begin
            step();
            c++;
        end
        chk("reach_wr", n_wr, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_timeout"}, 32'(timeout_o), 0);
        chk({tag, "_ready"}, 32'(req_ready_o), 0);
        chk({tag, "_wr_en"}, 32'(fifo_wr_en_o), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_last = N - 1;
    endtask

    initial begin
        int c, ps;
        n_chk = 0; n_pass = 0; n_fail = 0; n_wr = 0;
        rst = 1'b1; req_valid_i = '0; req_last_i = '0; req_data_i = '0; fifo_full_i = 1'b0;
        full_drv = 0; rnd_full = 0; rnd_mode = 0; gapmax = 0; mdl_last = N - 1;
        s_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            blen[k] = 0; bptr[k] = 0; gap[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // single requester, three bytes
        load_pkt(0, 3, 8'h11, 8'h11);
        build_expected();
        drain("single", 50);

        // two requesters from reset: order 0,2,0
        do_reset();
        load_pkt(0, 2, 8'h40, 8'h01);
        load_pkt(0, 1, 8'h60, 8'h01);
        load_pkt(2, 3, 8'h50, 8'h01);
        build_expected();
        drain("rr_order", 80);

        // FIFO full for five cycles mid-packet
        load_pkt(1, 6, 8'hB0, 8'h01);
        build_expected();
        run_until_wr(n_wr + HDR + 2, 50);
        full_drv = 1;
        repeat (5) begin
            step();
            chk("stall_wr", 32'(s_wr), 0);
            chk("stall_ready", 32'(s_ready), 0);
            chk("stall_timeout", 32'(s_to), 0);
            chk("stall_busy", 32'(s_busy), 1);
        end
        full_drv = 0;
        drain("stall", 50);

        // owner goes silent after one byte -> revoke, next requester served
        load_pkt(2, 2, 8'h55, 8'h11);
        load_pkt(3, 2, 8'h70, 8'h01);
        push_hdr(2); push_exp(2, 8'h55);
        push_hdr(3); push_exp(3, 8'h70); push_exp(3, 8'h71);
        mdl_last = 3;
        run_until_wr(n_wr + HDR + 1, 50);
        gap[2] = 100000;
        c = 0;
        do begin
            step();
            c++;
        end while (!s_to && c < 40);
        chk("timeout_idle_cycles", c - 1, TO);
        blen[2] = bptr[2];
        gap[2] = 0;
        step();
        chk("timeout_pulse_width", 32'(s_to), 0);
        chk("grant_after_timeout", 32'(s_grant), 32'b1000);
        drain("timeout", 50);

        // reset mid-packet, requester 1 waiting
        load_pkt(2, 6, 8'hC0, 8'h01);
        ps = blen[2] - 6;
        build_expected();
        run_until_wr(n_wr + HDR + 2, 50);
        load_pkt(1, 2, 8'hD0, 8'h01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("midpkt_rst");
        bptr[2] = ps;
        exp_q.delete();
        own_q.delete();
        step();
        step();
        rst = 1'b0;
        mdl_last = N - 1;
        build_expected();
        step();
        chk("grant_after_rst", 32'(s_grant), 32'b0010);
        drain("post_rst", 80);

        // randomized packets, gaps and FIFO back-pressure
        gapmax = 3; rnd_full = 1; rnd_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                int np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) load_pkt(k, $urandom_range(1, 5), 8'h00, 8'h00);
            end
            build_expected();
            drain("random", 2000);
        end
        rnd_full = 0; rnd_mode = 0; full_drv = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
